mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder to the CPU's multicycle memory initiator.
- Accepts one request at a time (word/byte/halfword read or write) over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a single-cycle response with data and an error flag.
- Storage is an internal register array, so memory timing and stalls can be exercised on the datapath.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; legal byte addresses are 0 to DEPTH_WORDS*4-1.
- WAIT_CYCLES, 2, wait states between accept and response; range 0-15.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_size  input  2  access size: 00 word, 01 byte, 10 halfword; 11 is illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte and halfword stores use the low bits.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data, zero-extended for byte and halfword reads.
- rsp_err  output  1  request rejected; qualified by rsp_valid.
- busy  output  1  a transaction is in flight (state is not IDLE).

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - state to IDLE and the wait counter to 0;
  - all memory words to 0;
  - rsp_valid, rsp_err and busy to 0;
  - rsp_rdata to 0.
- After reset, req_ready=1.
- A reset asserted mid-transaction aborts it: no write is committed and no response is issued.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1. When req_valid=1 on a clock edge, latch req_wr, req_size, req_addr and req_wdata. If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT with the counter loaded to WAIT_CYCLES-1.
  - WAIT: req_ready=0. The counter decrements each cycle; go to RESP on the edge where it is 0.
  - RESP: req_ready=0 and rsp_valid=1 for exactly one cycle; return to IDLE on the next edge.
- Request inputs are ignored outside IDLE.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- There is no response backpressure; the initiator must sample on the rsp_valid cycle.
- Addressing:
  - word index = addr[31:2];
  - lane = addr[1:0];
  - byte lanes are little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24;
  - halfword at addr[1]=0 is bits 15:0, at addr[1]=1 is bits 31:16.
- rsp_err=1 (in RESP) when any of the following holds:
  - word index ≥ DEPTH_WORDS;
  - size=word and addr[1:0]≠0;
  - size=halfword and addr[0]=1;
  - size=11.
- On error: no write occurs and rsp_rdata=0.
- Reads: rsp_rdata is driven in RESP with the data selected by size and lane, zero-extended. rsp_rdata holds its value after RESP until the next RESP.
- Writes:
  - Only the addressed lane(s) are modified: byte writes wdata[7:0], halfword writes wdata[15:0], word writes all 32 bits.
  - Other lanes keep their old contents.
  - The write commits on the edge leaving RESP.
  - rsp_rdata is 0 on a write response.
- Read-after-write: any later accepted read observes the new data.
- busy = 1 in WAIT and RESP.

Test Plan:
1. Reset, then write word 0xDEADBEEF at 0x10 and read word at 0x10 → read rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid arrives exactly 3 cycles after each accept (WAIT_CYCLES=2).
2. After test 1, write byte 0x55 at 0x12, then read word at 0x10 → 0xDE55BEEF; byte read at 0x13 → 0x000000DE.
3. Halfword read at 0x12 → 0x0000DE55; halfword read at 0x11 → rsp_err=1, rsp_rdata=0, memory unchanged.
4. Write word 0x1 at DEPTH_WORDS*4 (0x100) → rsp_err=1; readback at 0x0 is still 0; size=11 request → rsp_err=1.
5. Accept a word write to 0x20 and pull reset low during WAIT → no rsp_valid, req_ready=1 after reset release, read at 0x20 returns 0.
6. With WAIT_CYCLES=0, hold req_valid high for back-to-back reads → rsp_valid on the cycle after each accept; req_ready toggles 1,0,1,0; no request is dropped or duplicated.

Source files
------------

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: register-array storage, byte/half/word access, WAIT_CYCLES wait states.
// Latency WAIT_CYCLES+1 from accept to the one-cycle rsp_valid pulse; req_ready low while busy, no response backpressure.
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [29:0] widx;
    logic        err;
    logic [4:0]  sh;
    logic [31:0] rd_word, rd_sel, wr_rep, wr_word;
    logic [3:0]  be;
    logic        wr_en;

    // Datapath works entirely from the latched request, so inputs are don't-care outside IDLE.
    always_comb begin
        widx    = addr_q[31:2];
        sh      = {addr_q[1:0], 3'b000};
        err     = (widx >= 30'(DEPTH_WORDS)) || (size_q == 2'b11) ||
                  (size_q == 2'b00 && addr_q[1:0] != 2'b00) ||
                  (size_q == 2'b10 && addr_q[0]);
        rd_word = err ? 32'h0 : mem_q[widx[AW-1:0]];
        rd_sel  = 32'h0;
        wr_rep  = wdata_q;
        be      = 4'b0000;
        case (size_q)
            2'b00: begin
                rd_sel = rd_word;
                be     = 4'b1111;
            end
            2'b01: begin
                rd_sel = {24'h0, 8'(rd_word >> sh)};
                wr_rep = {4{wdata_q[7:0]}};
                be     = 4'b0001 << addr_q[1:0];
            end
            2'b10: begin
                rd_sel = {16'h0, 16'(rd_word >> sh)};
                wr_rep = {2{wdata_q[15:0]}};
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = wr_rep[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = rsp_valid && err;
        rsp_rdata = rsp_valid ? (wr_q ? 32'h0 : rd_sel) : hold_q;
        hold_d    = rsp_rdata;
        wr_en     = rsp_valid && wr_q && !err;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            hold_q  <= 32'h0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            // Store commits on the edge leaving RESP.
            if (wr_en) mem_q[widx[AW-1:0]] <= wr_word;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a byte-addressed reference model.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic        req_valid = 1'b0, req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        v0 = 1'b0, wr0 = 1'b0;
    logic [1:0]  sz0 = 2'b00;
    logic [31:0] a0 = 32'h0, wd0 = 32'h0;
    logic        rdy0, rv0, re0, busy0;
    logic [31:0] rd0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mb [256];

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .Clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .Clk(clk), .reset(rst_n), .req_valid(v0), .req_ready(rdy0),
        .req_wr(wr0), .req_size(sz0), .req_addr(a0), .req_wdata(wd0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0), .busy(busy0)
    );

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        return (a > 32'hFF) || (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) ||
               (sz == 2'b10 && a[0]);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] sz, input logic [31:0] a);
        int b;
        if (model_err(sz, a)) return 32'h0;
        b = int'(a[7:0]);
        case (sz)
            2'b00:   return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
            2'b01:   return {24'h0, mb[b]};
            default: return {16'h0, mb[b+1], mb[b]};
        endcase
    endfunction

    task automatic model_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        int b;
        if (model_err(sz, a)) return;
        b = int'(a[7:0]);
        n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 1 : 2;
        for (int i = 0; i < n; i++) mb[b+i] = wd[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    endtask

    // One transaction on the WAIT_CYCLES=2 instance; lat counts edges from accept to the rsp_valid cycle, -1 on timeout.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'h0; er = 1'b0; lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rd = rsp_rdata; er = rsp_err; lat = k;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, er, lat);
        model_write(2'b00, 32'h10, 32'hDEADBEEF);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL word_wr_latency: got %0d expected 3", lat); end
        n_checks++; if ({er, rd} !== 33'h0) begin n_fail++; $display("FAIL word_wr_rsp: got err=%b data=%h expected 0/0", er, rd); end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL word_rd_latency: got %0d expected 3", lat); end
        n_checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL word_rd: got err=%b data=%h expected 0/deadbeef", er, rd); end
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rdata_hold: got valid=%b data=%h expected 0/deadbeef", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b01, 32'h12, 32'hAAAAAA55, rd, er, lat);
        model_write(2'b01, 32'h12, 32'hAAAAAA55);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL byte_wr_err: got %b expected 0", er); end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL byte_merge: got %h expected de55beef", rd); end
        do_req(1'b0, 2'b01, 32'h13, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b0, 32'h000000DE}) begin n_fail++; $display("FAIL byte_rd: got err=%b data=%h expected 0/000000de", er, rd); end
    endtask

    task automatic test_halfword();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 2'b10, 32'h12, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b0, 32'h0000DE55}) begin n_fail++; $display("FAIL half_rd: got err=%b data=%h expected 0/0000de55", er, rd); end
        do_req(1'b0, 2'b10, 32'h11, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL half_misaligned: got err=%b data=%h expected 1/0", er, rd); end
        do_req(1'b1, 2'b10, 32'h11, 32'hFFFF, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL half_wr_misaligned: got %b expected 1", er); end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL half_mem_unchanged: got %h expected de55beef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b00, 32'h100, 32'h1, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL oob_wr: got err=%b data=%h expected 1/0", er, rd); end
        do_req(1'b0, 2'b00, 32'h0, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== 33'h0) begin n_fail++; $display("FAIL oob_no_alias: got err=%b data=%h expected 0/0", er, rd); end
        do_req(1'b1, 2'b11, 32'h10, 32'h12345678, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL size11_wr: got %b expected 1", er); end
        do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL size11_rd: got err=%b data=%h expected 1/0", er, rd); end
        do_req(1'b0, 2'b00, 32'h12, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL word_misaligned: got err=%b data=%h expected 1/0", er, rd); end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL err_mem_unchanged: got %h expected de55beef", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd; logic er, wr, exp_err; logic [1:0] sz; int lat;
        for (int t = 0; t < 60; t++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h10F));
            wd = $urandom;
            exp_err = model_err(sz, a);
            exp_rd  = wr ? 32'h0 : model_read(sz, a);
            do_req(wr, sz, a, wd, rd, er, lat);
            if (wr) model_write(sz, a, wd);
            n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 3", t, lat); end
            n_checks++; if (er !== exp_err) begin n_fail++; $display("FAIL rand_err[%0d]: addr=%h size=%0d got %b expected %b", t, a, sz, er, exp_err); end
            n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata[%0d]: addr=%h size=%0d got %h expected %h", t, a, sz, rd, exp_rd); end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; logic saw_rsp;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_in_wait: got %b expected 1", busy); end
        rst_n = 1'b0;
        saw_rsp = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid) saw_rsp = 1'b1; end
        rst_n = 1'b1;
        model_clear();
        repeat (4) begin @(negedge clk); if (rsp_valid) saw_rsp = 1'b1; end
        n_checks++; if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got rsp_valid=%b expected 0", saw_rsp); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
        do_req(1'b0, 2'b00, 32'h20, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== 33'h0) begin n_fail++; $display("FAIL abort_no_commit: got err=%b data=%h expected 0/0", er, rd); end
        do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_clears_mem: got %h expected 0", rd); end
    endtask

    // Zero-wait instance with req_valid held high: accept every other cycle, response the cycle after each accept.
    task automatic test_back_to_back();
        localparam int N = 9;
        logic        t_wr [N] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  t_sz [N] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [31:0] t_a  [N] = '{32'h40, 32'h41, 32'h42, 32'h40, 32'h43, 32'h40, 32'h43, 32'h3C, 32'h44};
        logic [31:0] t_wd [N] = '{32'hCAFEF00D, 32'hAB77, 32'h99991234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [32:0] expq [$];
        logic [32:0] e;
        int idx = 0;
        int nrsp = 0;
        logic acc, acc_prev;
        acc_prev = 1'b0;
        for (int k = 0; k < 2*N + 4; k++) begin
            @(negedge clk);
            n_checks++; if (rv0 !== acc_prev) begin n_fail++; $display("FAIL b2b_rsp_timing[%0d]: got rsp_valid=%b expected %b", k, rv0, acc_prev); end
            if (rv0) begin
                nrsp++;
                e = (expq.size() > 0) ? expq.pop_front() : 33'h1_FFFF_FFFF;
                n_checks++; if ({re0, rd0} !== e) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got err=%b data=%h expected err=%b data=%h", nrsp, re0, rd0, e[32], e[31:0]); end
            end
            if (k < 2*N) begin
                n_checks++; if (rdy0 !== (k % 2 == 0)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, rdy0, (k % 2 == 0)); end
            end
            if (idx < N) begin
                v0 = 1'b1; wr0 = t_wr[idx]; sz0 = t_sz[idx]; a0 = t_a[idx]; wd0 = t_wd[idx];
            end else begin
                v0 = 1'b0;
            end
            acc = rdy0 && (idx < N);
            if (acc) begin
                expq.push_back({model_err(t_sz[idx], t_a[idx]), t_wr[idx] ? 32'h0 : model_read(t_sz[idx], t_a[idx])});
                if (t_wr[idx]) model_write(t_sz[idx], t_a[idx], t_wd[idx]);
                idx++;
            end
            acc_prev = acc;
        end
        n_checks++; if (nrsp !== N) begin n_fail++; $display("FAIL b2b_count: got %0d responses expected %0d", nrsp, N); end
        n_checks++; if (expq.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d unanswered expected 0", expq.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_halfword();
        test_errors();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
